// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron readout blocks.
//   state_t         : window FSM states of the spike rate decoder
//   CNT_W_DEF       : default spike counter width
//   WIN_W_DEF       : default window / latency width
//   spike_result_t  : one completed window result at the default widths
package snn_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic [WIN_W_DEF-1:0] lat;
        logic                 no_spike;
    } spike_result_t;

endpackage

// File: rtl/spike_result_reg.sv
// Valid/ready holding register for one window result.
// A load is taken when the register is empty or is being accepted in the
// same cycle; otherwise the new result is dropped and overrun is set.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : a window completed this cycle, load_data holds its result
//   load_data    : result of the completed window
//   out_ready    : consumer accepts the held result when out_valid is high
//   overrun_clr  : clears the sticky overrun flag (a same-cycle set wins)
//   out_valid    : result holds an unaccepted value
//   result       : held result
//   overrun      : sticky, a completed window was dropped
module spike_result_reg
    import snn_pkg::*;
#(
    parameter type result_t = spike_result_t
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  result_t load_data,
    input  logic    out_ready,
    input  logic    overrun_clr,
    output logic    out_valid,
    output result_t result,
    output logic    overrun
);

    logic    valid_r;
    logic    valid_nxt_s;
    result_t data_r;
    result_t data_nxt_s;
    logic    overrun_r;
    logic    overrun_nxt_s;
    logic    load_ok_s;

    // Next-state of the holding register, the valid flag and the overrun flag.
    always_comb begin
        valid_nxt_s   = valid_r;
        data_nxt_s    = data_r;
        overrun_nxt_s = overrun_r;
        // Space is available if empty or the held value leaves this cycle.
        load_ok_s     = (~valid_r) | out_ready;

        if (load && load_ok_s) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = load_data;
        end else if (!load && valid_r && out_ready) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end

        if (load && !load_ok_s) begin
            overrun_nxt_s = 1'b1;
        end else if (overrun_clr) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // Result, valid and overrun registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            data_r    <= '0;
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= valid_nxt_s;
            data_r    <= data_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign out_valid = valid_r;
    assign result    = data_r;
    assign overrun   = overrun_r;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes of one 1-bit spike train over a
// programmable window and reports count and first-spike latency through a
// valid/ready result port.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   enable           : 0 aborts a running window and returns to IDLE
//   start            : begin a window while IDLE (window_len must be non-zero)
//   continuous       : restart immediately at window end (window_len re-sampled)
//   window_len       : window length in cycles, sampled at start/reload
//   spike_in         : spike sample, one per cycle
//   out_valid/out_ready : result handshake
//   spike_count      : saturating spike count of the reported window
//   first_spike_lat  : index of the first spike, window length if none
//   no_spike         : reported window had no spike
//   overrun          : sticky, a completed window was dropped
//   overrun_clr      : clears overrun
//   busy             : a window is being counted
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             continuous,
    input  logic [WIN_W-1:0] window_len,
    input  logic             spike_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] spike_count,
    output logic [WIN_W-1:0] first_spike_lat,
    output logic             no_spike,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             busy
);

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [WIN_W-1:0] lat;
        logic             no_spike;
    } res_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIN_W-1:0] len_r;
    logic [WIN_W-1:0] len_nxt_s;
    logic [WIN_W-1:0] win_cnt_r;
    logic [WIN_W-1:0] win_cnt_nxt_s;
    logic [CNT_W-1:0] acc_cnt_r;
    logic [CNT_W-1:0] acc_cnt_nxt_s;
    logic [WIN_W-1:0] lat_r;
    logic [WIN_W-1:0] lat_nxt_s;
    logic             seen_r;
    logic             seen_nxt_s;
    logic             busy_r;

    // Counters including the current sample.
    logic [CNT_W-1:0] acc_smp_s;
    logic [WIN_W-1:0] lat_smp_s;
    logic             seen_smp_s;
    logic             win_end_s;
    logic             len_zero_s;

    logic             load_s;
    res_t             load_data_s;
    res_t             result_s;

    // Fold the current spike sample into count, latency and seen flag.
    always_comb begin
        acc_smp_s  = acc_cnt_r;
        lat_smp_s  = lat_r;
        seen_smp_s = seen_r;
        if (spike_in) begin
            if (acc_cnt_r != {CNT_W{1'b1}}) begin
                acc_smp_s = acc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                acc_smp_s = acc_cnt_r;
            end
            if (!seen_r) begin
                lat_smp_s  = win_cnt_r;
                seen_smp_s = 1'b1;
            end else begin
                lat_smp_s  = lat_r;
                seen_smp_s = seen_r;
            end
        end else begin
            acc_smp_s  = acc_cnt_r;
            lat_smp_s  = lat_r;
            seen_smp_s = seen_r;
        end
    end

    assign win_end_s  = (win_cnt_r == (len_r - {{(WIN_W-1){1'b0}}, 1'b1}));
    assign len_zero_s = (window_len == {WIN_W{1'b0}});

    // Window FSM next-state, counter updates and result load generation.
    always_comb begin
        state_nxt_s   = state_r;
        len_nxt_s     = len_r;
        win_cnt_nxt_s = win_cnt_r;
        acc_cnt_nxt_s = acc_cnt_r;
        lat_nxt_s     = lat_r;
        seen_nxt_s    = seen_r;
        load_s        = 1'b0;
        load_data_s   = '0;

        case (state_r)
            IDLE: begin
                if (enable && start && !len_zero_s) begin
                    state_nxt_s   = COUNT;
                    len_nxt_s     = window_len;
                    win_cnt_nxt_s = {WIN_W{1'b0}};
                    acc_cnt_nxt_s = {CNT_W{1'b0}};
                    lat_nxt_s     = {WIN_W{1'b0}};
                    seen_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COUNT: begin
                if (!enable) begin
                    // Abort: the partial window is discarded without a result.
                    state_nxt_s   = IDLE;
                    win_cnt_nxt_s = {WIN_W{1'b0}};
                    acc_cnt_nxt_s = {CNT_W{1'b0}};
                    lat_nxt_s     = {WIN_W{1'b0}};
                    seen_nxt_s    = 1'b0;
                end else if (win_end_s) begin
                    load_s               = 1'b1;
                    load_data_s.count    = acc_smp_s;
                    load_data_s.lat      = seen_smp_s ? lat_smp_s : len_r;
                    load_data_s.no_spike = ~seen_smp_s;
                    win_cnt_nxt_s        = {WIN_W{1'b0}};
                    acc_cnt_nxt_s        = {CNT_W{1'b0}};
                    lat_nxt_s            = {WIN_W{1'b0}};
                    seen_nxt_s           = 1'b0;
                    if (continuous && !len_zero_s) begin
                        state_nxt_s = COUNT;
                        len_nxt_s   = window_len;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    win_cnt_nxt_s = win_cnt_r + {{(WIN_W-1){1'b0}}, 1'b1};
                    acc_cnt_nxt_s = acc_smp_s;
                    lat_nxt_s     = lat_smp_s;
                    seen_nxt_s    = seen_smp_s;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, window counters and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            len_r     <= {WIN_W{1'b0}};
            win_cnt_r <= {WIN_W{1'b0}};
            acc_cnt_r <= {CNT_W{1'b0}};
            lat_r     <= {WIN_W{1'b0}};
            seen_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            len_r     <= len_nxt_s;
            win_cnt_r <= win_cnt_nxt_s;
            acc_cnt_r <= acc_cnt_nxt_s;
            lat_r     <= lat_nxt_s;
            seen_r    <= seen_nxt_s;
            busy_r    <= (state_nxt_s == COUNT);
        end
    end

    spike_result_reg #(
        .result_t (res_t)
    ) u_result (
        .clk         (clk),
        .rst_n       (reset),
        .load        (load_s),
        .load_data   (load_data_s),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .result      (result_s),
        .overrun     (overrun)
    );

    assign spike_count     = result_s.count;
    assign first_spike_lat = result_s.lat;
    assign no_spike        = result_s.no_spike;
    assign busy            = busy_r;

endmodule
